// File: rtl/writeback_queue.sv
// Write-side initiator for the register file: two producers (mem older than alu) feed an
// in-order FIFO drained onto one write port, with forwarding lookups. Optional WBQ_STATS_EN adds stall_cycles.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_sel,
  input  logic [DATA_W-1:0]          mem_dat,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_sel,
  input  logic [DATA_W-1:0]          alu_dat,
  input  logic                       drain_en,
  output logic                       WEN,
  output logic [ADDR_W-1:0]          wsel,
  output logic [DATA_W-1:0]          wdat,
  input  logic [ADDR_W-1:0]          rsel1,
  input  logic [ADDR_W-1:0]          rsel2,
  output logic                       fwd1_hit,
  output logic [DATA_W-1:0]          fwd1_dat,
  output logic                       fwd2_hit,
  output logic [DATA_W-1:0]          fwd2_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
`ifdef WBQ_STATS_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] sel_mem [DEPTH];
  logic [DATA_W-1:0] dat_mem [DEPTH];

  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] free;
  logic          mem_push, alu_push, pop;
  logic [PW-1:0] alu_slot;

  assign free      = CW'(DEPTH) - count_reg;
  assign mem_ready = (free >= CW'(1));
  assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);

  // Register 0 transfers complete the handshake but never occupy a slot.
  assign mem_push = mem_valid && mem_ready && (mem_sel != '0);
  assign alu_push = alu_valid && alu_ready && (alu_sel != '0);
  assign pop      = !empty && drain_en;
  assign alu_slot = mem_push ? tail_reg + PW'(1) : tail_reg;

  assign count = count_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign WEN   = pop;
  assign wsel  = sel_mem[head_reg];
  assign wdat  = dat_mem[head_reg];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (pop)
        head_reg <= head_reg + PW'(1);
      tail_reg  <= tail_reg + PW'(mem_push) + PW'(alu_push);
      count_reg <= count_reg + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  // Payload storage needs no reset: occupancy is tracked solely by head/count.
  always_ff @(posedge CLK) begin
    if (mem_push) begin
      sel_mem[tail_reg] <= mem_sel;
      dat_mem[tail_reg] <= mem_dat;
    end
    if (alu_push) begin
      sel_mem[alu_slot] <= alu_sel;
      dat_mem[alu_slot] <= alu_dat;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] rsel);
    logic [DATA_W:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_reg + PW'(i);
      if ((CW'(i) < count_reg) && (rsel != '0) && (sel_mem[idx] == rsel))
        res = {1'b1, dat_mem[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_dat} = lookup(rsel1);
    {fwd2_hit, fwd2_dat} = lookup(rsel2);
  end

`ifdef WBQ_STATS_EN
  logic stall;
  assign stall = (mem_valid && !mem_ready) || (alu_valid && !alu_ready);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

  assert property (@(posedge CLK) disable iff (RST) count_reg <= CW'(DEPTH));

endmodule
